// File: rtl/tdr_pkg.sv
// Shared constants, state encoding and sizing helper for the TDR sweep sequencer.
package tdr_pkg;

  localparam int CLK_FREQ            = 12_000_000;
  localparam int TAP_W_DEF           = 6;
  localparam int REP_W_DEF           = 8;
  localparam int SETTLE_CYCLES_DEF   = 16;
  localparam int CAPTURE_LAT_DEF     = 4;
  localparam int INTERVAL_US         = 100;
  localparam int INTERVAL_CYCLES_DEF = (CLK_FREQ / 1_000_000) * INTERVAL_US;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_FIRE    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_EMIT    = 3'd5,
    ST_DONE    = 3'd6
  } tdr_state_e;

  // Counter width able to hold the larger of two cycle budgets.
  function automatic int tmr_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/tdr_cycle_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
// A load of N makes expired_o rise N+1 cycles after the load cycle.
module tdr_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tdr_sweep_sequencer.sv
// Equivalent-time TDR sweep: per tap, settle, fire a burst of spaced triggers, count hits,
// then emit one result word; EMIT stalls the sweep until result_ready_i.
module tdr_sweep_sequencer
  import tdr_pkg::*;
#(
  parameter int TAP_W           = TAP_W_DEF,
  parameter int REP_W           = REP_W_DEF,
  parameter int SETTLE_CYCLES   = SETTLE_CYCLES_DEF,
  parameter int CAPTURE_LAT     = CAPTURE_LAT_DEF,
  parameter int INTERVAL_CYCLES = INTERVAL_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [TAP_W-1:0] num_taps_i,
  input  logic [REP_W-1:0] reps_i,
  input  logic             sample_i,
  output logic             trigger_o,
  output logic [TAP_W-1:0] delay_tap_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [TAP_W-1:0] result_tap_o,
  output logic [REP_W-1:0] result_hits_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int TMR_W = tmr_width(INTERVAL_CYCLES, SETTLE_CYCLES);
  // The interval timer is reloaded at the capture point, so the capture and
  // holdoff loads together span exactly INTERVAL_CYCLES from FIRE to FIRE.
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] CAPTURE_LD = TMR_W'(CAPTURE_LAT - 1);
  localparam logic [TMR_W-1:0] HOLDOFF_LD = TMR_W'(INTERVAL_CYCLES - CAPTURE_LAT - 2);

  tdr_state_e       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] num_taps_q, num_taps_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] acc_q, acc_d;

  logic             settle_load, settle_exp;
  logic             ivl_load, ivl_exp;
  logic [TMR_W-1:0] ivl_val;

  tdr_cycle_timer #(.W(TMR_W)) u_settle_tmr (
    .clk       (clk),
    .areset_n  (areset_n),
    .load_i    (settle_load),
    .load_val_i(SETTLE_LD),
    .expired_o (settle_exp)
  );

  tdr_cycle_timer #(.W(TMR_W)) u_ivl_tmr (
    .clk       (clk),
    .areset_n  (areset_n),
    .load_i    (ivl_load),
    .load_val_i(ivl_val),
    .expired_o (ivl_exp)
  );

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    num_taps_d  = num_taps_q;
    reps_d      = reps_q;
    rep_d       = rep_q;
    acc_d       = acc_q;
    settle_load = 1'b0;
    ivl_load    = 1'b0;
    ivl_val     = CAPTURE_LD;

    if (abort_i) begin
      state_d = ST_IDLE;
      tap_d   = '0;
      rep_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            num_taps_d = num_taps_i;
            reps_d     = reps_i;
            tap_d      = '0;
            rep_d      = '0;
            acc_d      = '0;
            if ((num_taps_i == '0) || (reps_i == '0)) begin
              state_d = ST_DONE;
            end else begin
              state_d     = ST_SETTLE;
              settle_load = 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_exp) state_d = ST_FIRE;
        end
        ST_FIRE: begin
          ivl_load = 1'b1;
          ivl_val  = CAPTURE_LD;
          rep_d    = rep_q + REP_W'(1);
          state_d  = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (ivl_exp) begin
            acc_d    = acc_q + {{(REP_W-1){1'b0}}, sample_i};
            ivl_load = 1'b1;
            ivl_val  = HOLDOFF_LD;
            state_d  = ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (ivl_exp) state_d = (rep_q == reps_q) ? ST_EMIT : ST_FIRE;
        end
        ST_EMIT: begin
          if (result_ready_i) begin
            acc_d = '0;
            rep_d = '0;
            if (tap_q == num_taps_q - TAP_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              tap_d       = tap_q + TAP_W'(1);
              settle_load = 1'b1;
              state_d     = ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          tap_d   = '0;
          state_d = ST_IDLE;
        end
        default: begin
          tap_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= ST_IDLE;
      tap_q      <= '0;
      num_taps_q <= '0;
      reps_q     <= '0;
      rep_q      <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      num_taps_q <= num_taps_d;
      reps_q     <= reps_d;
      rep_q      <= rep_d;
      acc_q      <= acc_d;
    end
  end

  // Outputs decode straight from registers so reset clears them without a clock edge.
  assign trigger_o      = (state_q == ST_FIRE);
  assign result_valid_o = (state_q == ST_EMIT);
  assign result_tap_o   = result_valid_o ? tap_q : '0;
  assign result_hits_o  = result_valid_o ? acc_q : '0;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign delay_tap_o    = tap_q;

endmodule

// File: tb/tb_tdr_sweep_sequencer.sv
// Bench for tdr_sweep_sequencer: per-cycle timeline model plus directed sweeps.
module tb_tdr_sweep_sequencer;

  localparam int S   = 4;
  localparam int LAT = 2;
  localparam int IV  = 10;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       start_i, abort_i, sample_i, result_ready_i;
  logic [5:0] num_taps_i, result_tap_o, delay_tap_o;
  logic [7:0] reps_i, result_hits_o;
  logic       trigger_o, result_valid_o, busy_o, done_o;

  tdr_sweep_sequencer #(
    .TAP_W(6), .REP_W(8), .SETTLE_CYCLES(S), .CAPTURE_LAT(LAT), .INTERVAL_CYCLES(IV)
  ) dut (
    .clk           (clk),
    .areset_n      (areset_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .num_taps_i    (num_taps_i),
    .reps_i        (reps_i),
    .sample_i      (sample_i),
    .trigger_o     (trigger_o),
    .delay_tap_o   (delay_tap_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_tap_o  (result_tap_o),
    .result_hits_o (result_hits_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: phase 0 idle, 1 sweeping, 2 done pulse; tap activity is derived
  // from the offset into the tap's segment rather than from any state machine.
  int m_ph = 0, m_nt = 0, m_reps = 0, m_tap = 0, m_hits = 0, m_seg = 0;

  // Observations of the DUT.
  logic [1:0] th = 2'b00;
  int last_trig = -1, tap_chg = -1, prev_delay = 0;
  int trig_cnt = 0, done_cnt = 0;
  int gaps[$], sgaps[$], rtaps[$], rhits[$];

  bit smode  = 1'b0;
  bit sconst = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step();
    int off, emit_at;
    bit e_trig, e_valid, e_busy, e_done, cap;
    if (!areset_n) begin
      m_ph = 0; last_trig = -1; tap_chg = -1; prev_delay = 0; th = 2'b00;
    end else begin
      e_trig = 0; e_valid = 0; e_busy = 0; e_done = 0; cap = 0;
      off = cyc - m_seg;
      emit_at = S + m_reps * IV;
      if (m_ph == 1) begin
        e_busy = 1;
        if (off >= emit_at) e_valid = 1;
        else if (off >= S) begin
          e_trig = ((off - S) % IV == 0);
          cap    = ((off - S) % IV == LAT);
        end
      end else if (m_ph == 2) begin
        e_busy = 1; e_done = 1;
      end
      chk("m_trigger", int'(trigger_o), int'(e_trig));
      chk("m_valid", int'(result_valid_o), int'(e_valid));
      chk("m_busy", int'(busy_o), int'(e_busy));
      chk("m_done", int'(done_o), int'(e_done));
      if (m_ph != 2) chk("m_delay_tap", int'(delay_tap_o), (m_ph == 1) ? m_tap : 0);
      if (e_valid) begin
        chk("m_result_tap", int'(result_tap_o), m_tap);
        chk("m_result_hits", int'(result_hits_o), m_hits);
      end

      if (trigger_o) begin
        trig_cnt++;
        if (last_trig >= 0) gaps.push_back(cyc - last_trig);
        if (tap_chg >= 0) sgaps.push_back(cyc - tap_chg);
        last_trig = cyc; tap_chg = -1;
      end
      if (int'(delay_tap_o) != prev_delay && delay_tap_o != 0) tap_chg = cyc;
      prev_delay = int'(delay_tap_o);
      if (done_o) done_cnt++;
      if (result_valid_o && result_ready_i) begin
        rtaps.push_back(int'(result_tap_o));
        rhits.push_back(int'(result_hits_o));
      end
      th = {th[0], trigger_o};

      if (abort_i) m_ph = 0;
      else if (m_ph == 0) begin
        if (start_i) begin
          m_nt = int'(num_taps_i); m_reps = int'(reps_i);
          m_tap = 0; m_hits = 0; last_trig = -1; tap_chg = -1;
          if (m_nt == 0 || m_reps == 0) m_ph = 2;
          else begin m_ph = 1; m_seg = cyc + 1; end
        end
      end else if (m_ph == 1) begin
        if (cap) m_hits += int'(sample_i);
        if (e_valid && result_ready_i) begin
          if (m_tap == m_nt - 1) m_ph = 2;
          else begin m_tap++; m_hits = 0; m_seg = cyc + 1; end
        end
      end else m_ph = 0;
    end
    cyc++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
      sample_i = smode ? th[1] : sconst;
    end
  endtask

  task automatic run_start(input int nt, input int rp);
    num_taps_i = 6'(nt); reps_i = 8'(rp); start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin tick(1); n++; end
    chk(nm, int'(busy_o), 0);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n = 0;
    while (!result_valid_o && n < budget) begin tick(1); n++; end
    chk(nm, int'(result_valid_o), 1);
  endtask

  task automatic check_results(input string nm, input int r0, input int ntaps, input int hits);
    chk({nm, "_count"}, rtaps.size() - r0, ntaps);
    if (rtaps.size() >= r0 + ntaps)
      for (int k = 0; k < ntaps; k++) begin
        chk({nm, "_tap"}, rtaps[r0 + k], k);
        chk({nm, "_hits"}, rhits[r0 + k], hits);
      end
  endtask

  // Within a tap triggers are 10 apart; across a tap boundary 4 settle + 10 + 1 emit = 15.
  task automatic check_gaps(input string nm, input int g0, input int reps, input int ntaps);
    chk({nm, "_count"}, gaps.size() - g0, ntaps * reps - 1);
    if (gaps.size() >= g0 + ntaps * reps - 1)
      for (int i = 0; i < ntaps * reps - 1; i++)
        chk({nm, "_gap"}, gaps[g0 + i], (i % reps == reps - 1) ? 15 : 10);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_trigger"}, int'(trigger_o), 0);
    chk({nm, "_valid"}, int'(result_valid_o), 0);
    chk({nm, "_busy"}, int'(busy_o), 0);
    chk({nm, "_done"}, int'(done_o), 0);
    chk({nm, "_delay_tap"}, int'(delay_tap_o), 0);
  endtask

  initial begin
    int t0, d0, r0, g0, s0, n;
    areset_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; sample_i = 1'b0;
    result_ready_i = 1'b1; num_taps_i = '0; reps_i = '0;
    tick(2);
    check_quiet("reset");
    chk("reset_result_tap", int'(result_tap_o), 0);
    chk("reset_result_hits", int'(result_hits_o), 0);
    areset_n = 1'b1;
    tick(2);

    // Basic sweep: 3 taps x 2 reps, always hit.
    sconst = 1'b1;
    t0 = trig_cnt; d0 = done_cnt; r0 = rtaps.size(); g0 = gaps.size(); s0 = sgaps.size();
    run_start(3, 2);
    wait_idle("basic_timeout", 300);
    chk("basic_triggers", trig_cnt - t0, 6);
    chk("basic_done", done_cnt - d0, 1);
    check_results("basic", r0, 3, 2);
    check_gaps("basic", g0, 2, 3);
    chk("basic_settle_count", sgaps.size() - s0, 2);
    for (int i = s0; i < sgaps.size(); i++) chk("basic_settle_gap", sgaps[i], 4);
    tick(2);
    chk("basic_busy_after", int'(busy_o), 0);

    // Sample only in the cycle exactly LAT after each trigger.
    smode = 1'b1;
    r0 = rtaps.size(); g0 = gaps.size();
    run_start(2, 3);
    wait_idle("lat_timeout", 300);
    check_results("lat", r0, 2, 3);
    check_gaps("lat", g0, 3, 2);
    smode = 1'b0; sconst = 1'b0;
    r0 = rtaps.size();
    run_start(1, 3);
    wait_idle("miss_timeout", 200);
    check_results("miss", r0, 1, 0);

    // Backpressure: hold EMIT for 20 cycles.
    sconst = 1'b1; result_ready_i = 1'b0;
    r0 = rtaps.size();
    run_start(2, 1);
    wait_valid("bp_wait_valid", 100);
    t0 = trig_cnt;
    tick(20);
    chk("bp_valid_held", int'(result_valid_o), 1);
    chk("bp_tap_held", int'(result_tap_o), 0);
    chk("bp_hits_held", int'(result_hits_o), 1);
    chk("bp_no_trigger", trig_cnt - t0, 0);
    result_ready_i = 1'b1;
    tick(1);
    chk("bp_next_tap", int'(delay_tap_o), 1);
    chk("bp_valid_dropped", int'(result_valid_o), 0);
    chk("bp_busy", int'(busy_o), 1);
    wait_idle("bp_timeout", 200);
    check_results("bp", r0, 2, 1);

    // Zero config: done the cycle after start, nothing else.
    t0 = trig_cnt; r0 = rtaps.size(); d0 = done_cnt;
    run_start(5, 0);
    chk("zero_reps_done", int'(done_o), 1);
    tick(1);
    chk("zero_reps_done_off", int'(done_o), 0);
    chk("zero_reps_busy", int'(busy_o), 0);
    run_start(0, 4);
    chk("zero_taps_done", int'(done_o), 1);
    tick(2);
    chk("zero_triggers", trig_cnt - t0, 0);
    chk("zero_results", rtaps.size() - r0, 0);
    chk("zero_done_count", done_cnt - d0, 2);

    // Abort mid-HOLDOFF of tap 1, then during EMIT, then together with start.
    d0 = done_cnt;
    run_start(3, 2);
    n = 0;
    while (delay_tap_o != 6'd1 && n < 200) begin tick(1); n++; end
    chk("abort_wait_tap1", int'(delay_tap_o), 1);
    tick(8);
    chk("abort_pre_busy", int'(busy_o), 1);
    abort_i = 1'b1; tick(1); abort_i = 1'b0;
    check_quiet("abort_holdoff");
    result_ready_i = 1'b0;
    run_start(2, 1);
    wait_valid("abort_wait_emit", 100);
    abort_i = 1'b1; tick(1); abort_i = 1'b0;
    check_quiet("abort_emit");
    result_ready_i = 1'b1;
    abort_i = 1'b1; start_i = 1'b1; tick(1); abort_i = 1'b0; start_i = 1'b0;
    check_quiet("abort_start");
    tick(3);
    chk("abort_no_done", done_cnt - d0, 0);
    t0 = trig_cnt; r0 = rtaps.size(); d0 = done_cnt;
    run_start(2, 2);
    wait_idle("clean_timeout", 200);
    chk("clean_triggers", trig_cnt - t0, 4);
    chk("clean_done", done_cnt - d0, 1);
    check_results("clean", r0, 2, 2);

    // Start and config changes while busy are ignored.
    t0 = trig_cnt; r0 = rtaps.size();
    run_start(2, 2);
    tick(30);
    num_taps_i = 6'd5; reps_i = 8'd7; start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    wait_idle("illegal_timeout", 200);
    chk("illegal_triggers", trig_cnt - t0, 4);
    check_results("illegal", r0, 2, 2);

    // Asynchronous reset in CAPTURE clears outputs without a clock edge.
    run_start(2, 2);
    n = 0;
    while (!trigger_o && n < 100) begin tick(1); n++; end
    chk("rst_wait_trigger", int'(trigger_o), 1);
    tick(1);
    chk("rst_pre_busy", int'(busy_o), 1);
    #2 areset_n = 1'b0;
    #1;
    check_quiet("rst_async");
    tick(1);
    areset_n = 1'b1;
    tick(3);
    chk("rst_idle", int'(busy_o), 0);
    r0 = rtaps.size();
    run_start(1, 1);
    wait_idle("rst_recover_timeout", 100);
    check_results("rst_recover", r0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdr_sweep_sequencer.md
Name: tdr_sweep_sequencer

Overview:
- Sequences an equivalent-time TDR sweep in the slow `clk` domain.
- For each delay tap it emits a burst of one-cycle pulse triggers toward the fast pulse generator and samples the synchronized comparator bit a fixed latency after each trigger.
- It counts hits per tap and streams one result word per tap over a valid/ready interface to the readout logic.
- It sits between the button/UART control logic and the pulse generator plus delay line, and replaces the free-running 1 s trigger.

Parameters:
- TAP_W, 6, width of delay tap index (max 64 taps).
- REP_W, 8, width of repetition count and hit accumulator.
- SETTLE_CYCLES, 16, clk cycles to wait after delay_tap_o changes before the first trigger at that tap.
- CAPTURE_LAT, 4, clk cycles from the trigger_o cycle to the cycle where sample_i is sampled (must be ≥1).
- INTERVAL_CYCLES, 1200, minimum trigger-to-trigger spacing in clk cycles (100 us at 12 MHz; must be > CAPTURE_LAT+1).

Ports:
- clk  in  1  system clock, 12 MHz.
- areset_n  in  1  asynchronous reset, active-low.
- start_i  in  1  single-cycle sweep start request.
- abort_i  in  1  single-cycle abort request.
- num_taps_i  in  TAP_W  taps per sweep; latched at start.
- reps_i  in  REP_W  triggers per tap; latched at start.
- sample_i  in  1  comparator bit, already synchronized to clk.
- trigger_o  out  1  one-cycle pulse trigger to the fast domain.
- delay_tap_o  out  TAP_W  current delay line tap.
- result_valid_o  out  1  result word available.
- result_ready_i  in  1  consumer accepts the result.
- result_tap_o  out  TAP_W  tap index of the result.
- result_hits_o  out  REP_W  number of sample_i=1 across reps at that tap.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Clock and reset: one clock `clk`; reset `areset_n` is asynchronous and active-low.
- Reset values: all outputs are 0 and the FSM is in IDLE.
- FSM states: IDLE, SETTLE, FIRE, CAPTURE, HOLDOFF, EMIT, DONE.
- IDLE: on start_i=1 (and abort_i=0), latch num_taps_i and reps_i, set tap=0 and acc=0.
  - If either latched value is 0, go to DONE with no triggers.
  - Otherwise go to SETTLE.
- SETTLE: delay_tap_o=tap. Wait exactly SETTLE_CYCLES cycles, then go to FIRE.
- FIRE: trigger_o=1 for exactly this one cycle. Start the interval counter at 1 and the rep counter. Go to CAPTURE.
- CAPTURE: sample sample_i in the cycle exactly CAPTURE_LAT cycles after FIRE. acc += sample_i. Go to HOLDOFF.
- HOLDOFF: wait until INTERVAL_CYCLES cycles have elapsed since FIRE.
  - If reps are remaining, go to FIRE. Consecutive triggers are therefore exactly INTERVAL_CYCLES apart.
  - If the last rep is done, go to EMIT.
- EMIT: result_valid_o=1, with result_tap_o=tap and result_hits_o=acc. These values stay stable until result_ready_i=1. A handshake may complete in the first EMIT cycle.
  - On handshake, clear acc.
  - If tap==num_taps−1, go to DONE. Otherwise tap+1, then SETTLE.
- DONE: done_o=1 for one cycle, then IDLE.
- Trigger spacing across taps: the SETTLE that follows HOLDOFF/EMIT always keeps trigger spacing ≥ INTERVAL_CYCLES.
- Trigger shape: trigger_o is never high for two consecutive cycles.
- busy_o: high in every state except IDLE.
- Accumulator width: acc is REP_W wide and cannot overflow, because hits ≤ reps ≤ 2^REP_W−1. The tap counter never wraps.
- start_i outside IDLE: ignored. Latched config is not updated mid-sweep.
- abort_i: from any state, go to IDLE on the next cycle.
  - trigger_o, result_valid_o and busy_o drop to 0. No done_o.
  - delay_tap_o returns to 0.
  - abort_i takes priority over start_i in the same cycle.
- Reset mid-sweep: immediate return to reset values. Any pending result is lost.

Decomposition:
- Package tdr_pkg holds:
  - the state enum;
  - CLK_FREQ=12_000_000;
  - default TAP_W/REP_W;
  - INTERVAL_CYCLES default derived from CLK_FREQ.
- One sub-module, tdr_cycle_timer: a loadable counter with an expiry flag, instantiated twice (settle timer, interval/capture timer).

Test Plan:
Bench parameters: SETTLE_CYCLES=4, CAPTURE_LAT=2, INTERVAL_CYCLES=10.
- Basic sweep: num_taps=3, reps=2, sample_i=1 constant, result_ready_i=1.
  - Expect 6 trigger_o pulses, each one cycle wide.
  - Expect results (0,2), (1,2), (2,2).
  - Expect done_o once, busy_o low afterwards.
- Timing check: measure the FIRE→FIRE gap = 10 cycles within a tap. Measure tap change→next trigger ≥ 4 cycles and trigger-to-trigger ≥ 10 cycles. Verify sample_i is sampled exactly 2 cycles after trigger_o, by toggling sample_i with 1 only in that cycle → hits=reps.
- Backpressure: result_ready_i=0 for 20 cycles in EMIT.
  - Expect result_valid_o held, data stable, no trigger_o.
  - On release, expect the handshake and the next tap's SETTLE.
- Zero config: reps=0 with num_taps=5, then num_taps=0 with reps=4.
  - Expect no trigger_o, no result_valid_o, and done_o one cycle after start.
- Abort: abort_i asserted mid-HOLDOFF of tap 1, then during EMIT.
  - Expect IDLE next cycle, all outputs 0, no done_o.
  - A following start_i runs a full clean sweep.
- Async reset and illegal start:
  - areset_n pulsed low mid-CAPTURE → outputs 0 immediately, with no clk edge needed.
  - start_i while busy → ignored; config changes mid-sweep have no effect.
